fetch_stage: RTL and testbench

//  IF stage plus IF/ID register of the 5-stage MIPS pipeline; feeds decode, where the control unit takes op=InstrD[31:26] and funct=InstrD[5:0].

---
 rtl/mips_pkg.sv | 29 ++
 rtl/if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS pipeline front end.
//   RESET_PC / NOP_INSTR : default reset PC and bubble instruction
//   OP_*/FUNCT_*         : decode field positions used by the control unit
//   JIDX_W               : width of the J-type instruction index
//   fetch_state_t        : fetch FSM states
//   jump_target()        : {PC+4[31:28], index, 2'b00}
package mips_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam int unsigned OP_MSB    = 31;
   localparam int unsigned OP_LSB    = 26;
   localparam int unsigned FUNCT_MSB = 5;
   localparam int unsigned FUNCT_LSB = 0;
   localparam int unsigned JIDX_W    = 26;

   typedef enum logic [1:0] {
      S_RESET,
      S_REQ,
      S_HOLD
   } fetch_state_t;

   function automatic logic [31:0] jump_target(input logic [3:0]        pc4_hi,
                                                input logic [JIDX_W-1:0] idx);
      return {pc4_hi, idx, 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_load             : capture i_instr / i_pc4 as a valid instruction
//   i_bubble           : replace instruction with NOP, clear valid, keep PC+4
//   (neither asserted) : hold current contents
//   o_instr, o_pc4, o_valid : register contents
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic        i_bubble,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc4;
   logic        r_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_instr <= NOP_INSTR;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (i_bubble) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc4   <= i_pc4;
         r_valid <= 1'b1;
      end
   end

   assign o_instr = r_instr;
   assign o_pc4   = r_pc4;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID register of the 5-stage MIPS pipeline.
//   clk, reset            : clock, asynchronous active-low reset
//   imem_req/addr         : instruction fetch request (addr stable until ready)
//   imem_ready/rdata      : fetch response, same-cycle ready allowed
//   StallD                : hold IF/ID and block new requests
//   JumpD, PCSrcD         : redirect from decode (jump wins), PCBranchD target
//   InstrD/PCPlus4D/ValidD: IF/ID contents
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        StallD,
   input  logic        JumpD,
   input  logic        PCSrcD,
   input  logic [31:0] PCBranchD,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   fetch_state_t r_state;
   logic [31:0]  r_pcf;
   logic [31:0]  r_req_addr;
   logic         r_kill;
   logic [31:0]  r_buf_instr;
   logic [31:0]  r_buf_pc4;

   logic         w_redirect;
   logic [31:0]  w_target;
   logic [31:0]  w_next_addr;
   logic         w_req;
   logic         w_load;
   logic         w_bubble;
   logic [31:0]  w_ld_instr;
   logic [31:0]  w_ld_pc4;

   always_comb begin
      w_redirect  = !StallD && (JumpD || PCSrcD);
      w_target    = JumpD ? jump_target(PCPlus4D[31:28], InstrD[JIDX_W-1:0])
                          : (PCBranchD & 32'hFFFF_FFFC);
      w_next_addr = r_req_addr + 32'd4;
      w_req       = (r_state == S_REQ);

      w_load     = 1'b0;
      w_bubble   = 1'b0;
      w_ld_instr = imem_rdata;
      w_ld_pc4   = w_next_addr;

      if (w_redirect) begin
         w_bubble = 1'b1;
      end else begin
         case (r_state)
            S_REQ: begin
               // a missing or squashed response leaves decode empty unless it is stalled
               if (!imem_ready || r_kill) w_bubble = !StallD;
               else                       w_load   = !StallD;
            end
            S_HOLD: begin
               if (!StallD) begin
                  w_load     = 1'b1;
                  w_ld_instr = r_buf_instr;
                  w_ld_pc4   = r_buf_pc4;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_RESET;
         r_pcf       <= RESET_PC;
         r_req_addr  <= RESET_PC;
         r_kill      <= 1'b0;
         r_buf_instr <= '0;
         r_buf_pc4   <= '0;
      end else if (w_redirect) begin
         r_pcf       <= w_target;
         r_buf_instr <= '0;
         r_buf_pc4   <= '0;
         r_state     <= S_REQ;
         // an unanswered request must keep its address; its response is discarded later
         if (w_req && !imem_ready) begin
            r_kill <= 1'b1;
         end else begin
            r_kill     <= 1'b0;
            r_req_addr <= w_target;
         end
      end else begin
         case (r_state)
            S_RESET: begin
               r_state    <= S_REQ;
               r_req_addr <= r_pcf;
            end
            S_REQ: begin
               if (imem_ready) begin
                  if (r_kill) begin
                     r_kill     <= 1'b0;
                     r_req_addr <= r_pcf;
                  end else begin
                     r_pcf <= w_next_addr;
                     if (StallD) begin
                        r_buf_instr <= imem_rdata;
                        r_buf_pc4   <= w_next_addr;
                        r_state     <= S_HOLD;
                     end else begin
                        r_req_addr <= w_next_addr;
                     end
                  end
               end
            end
            S_HOLD: begin
               if (!StallD) begin
                  r_req_addr <= r_pcf;
                  r_state    <= S_REQ;
               end
            end
            default: r_state <= S_RESET;
         endcase
      end
   end

   assign imem_req  = w_req;
   assign imem_addr = r_req_addr;

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .i_clk    (clk),
      .i_rst_n  (reset),
      .i_load   (w_load),
      .i_bubble (w_bubble),
      .i_instr  (w_ld_instr),
      .i_pc4    (w_ld_pc4),
      .o_instr  (InstrD),
      .o_pc4    (PCPlus4D),
      .o_valid  (ValidD)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized decode/memory behaviour,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        StallD;
   logic        JumpD;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .StallD     (StallD),
      .JumpD      (JumpD),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .InstrD     (InstrD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Model: next PC to fetch, address on the bus, whether the outstanding
   // response is wrong-path, a queue of responses parked during a stall,
   // and the instruction decode currently sees.
   typedef struct {
      logic [31:0] w;
      logic [31:0] p4;
   } parked_t;

   bit          m_started;
   bit          m_squash;
   logic [31:0] m_pc;
   logic [31:0] m_addr;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   bit          m_valid;
   parked_t     m_park[$];

   function automatic bit m_req();
      return m_started && (m_park.size() == 0);
   endfunction

   task automatic m_reset();
      m_started = 0; m_squash = 0; m_valid = 0;
      m_pc = '0; m_addr = '0; m_instr = '0; m_pc4 = '0;
      m_park.delete();
   endtask

   task automatic m_step(input bit stall, input bit j, input bit b,
                         input logic [31:0] bt, input bit rdy, input logic [31:0] rd);
      logic [31:0] tgt;
      logic [31:0] nxt;
      bit          req;
      req = m_req();
      tgt = j ? {m_pc4[31:28], m_instr[25:0], 2'b00} : (bt & 32'hFFFF_FFFC);
      nxt = m_addr + 32'd4;
      if (!stall && (j || b)) begin
         m_instr = '0; m_valid = 0; m_pc = tgt; m_started = 1;
         m_park.delete();
         if (req && !rdy) m_squash = 1;
         else begin m_squash = 0; m_addr = tgt; end
      end else if (!m_started) begin
         m_started = 1; m_addr = m_pc;
      end else if (m_park.size() != 0) begin
         if (!stall) begin
            m_instr = m_park[0].w; m_pc4 = m_park[0].p4; m_valid = 1;
            m_park.delete(); m_addr = m_pc;
         end
      end else if (rdy && !m_squash) begin
         m_pc = nxt;
         if (stall) m_park.push_back('{rd, nxt});
         else begin m_instr = rd; m_pc4 = nxt; m_valid = 1; m_addr = nxt; end
      end else begin
         if (rdy) begin m_squash = 0; m_addr = m_pc; end
         if (!stall) begin m_instr = '0; m_valid = 0; end
      end
   endtask

   task automatic check_all();
      chk("req",   32'(imem_req), 32'(m_req()));
      chk("addr",  imem_addr,     m_addr);
      chk("instr", InstrD,        m_instr);
      chk("pc4",   PCPlus4D,      m_pc4);
      chk("valid", 32'(ValidD),   32'(m_valid));
   endtask

   bit          force_en = 0;
   logic [31:0] force_word = '0;

   task automatic tick(input bit stall, input bit j, input bit b,
                       input logic [31:0] bt, input bit rdy);
      bit          r;
      logic [31:0] rd;
      r  = rdy && m_req();
      rd = force_en ? force_word : (m_addr | 32'h2000_0000);
      StallD = stall; JumpD = j; PCSrcD = b; PCBranchD = bt;
      imem_ready = r; imem_rdata = rd;
      @(posedge clk);
      m_step(stall, j, b, bt, r, rd);
      #1 check_all();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".req"},   32'(imem_req), 32'd0);
      chk({tag, ".addr"},  imem_addr,     32'd0);
      chk({tag, ".instr"}, InstrD,        32'd0);
      chk({tag, ".pc4"},   PCPlus4D,      32'd0);
      chk({tag, ".valid"}, 32'(ValidD),   32'd0);
   endtask

   initial begin
      reset = 1'b0; StallD = 0; JumpD = 0; PCSrcD = 0; PCBranchD = '0;
      imem_ready = 0; imem_rdata = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1 chk_reset_outputs("rst");
      reset = 1'b1;
      #1 chk_reset_outputs("idle");

      tick(0, 0, 0, 0, 0);
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, 32'h0);

      // zero-wait stream
      tick(0, 0, 0, 0, 1);
      chk("s0_instr", InstrD, 32'h2000_0000); chk("s0_pc4", PCPlus4D, 32'h4);
      tick(0, 0, 0, 0, 1);
      chk("s1_instr", InstrD, 32'h2000_0004); chk("s1_pc4", PCPlus4D, 32'h8);

      // wait states at 0x8
      tick(0, 0, 0, 0, 0);
      chk("ws_addr", imem_addr, 32'h8); chk("ws_valid", 32'(ValidD), 32'd0);
      tick(0, 0, 0, 0, 0);
      chk("ws_addr2", imem_addr, 32'h8);
      tick(0, 0, 0, 0, 1);
      chk("ws_instr", InstrD, 32'h2000_0008);

      // response lands during stall
      tick(1, 0, 0, 0, 1);
      chk("st_instr", InstrD, 32'h2000_0008); chk("st_req", 32'(imem_req), 32'd0);
      tick(1, 0, 0, 0, 1);
      chk("st_req2", 32'(imem_req), 32'd0);
      tick(0, 0, 0, 0, 0);
      chk("st_rel_instr", InstrD, 32'h2000_000C); chk("st_rel_addr", imem_addr, 32'h10);

      // jump with same-cycle ready
      force_en = 1; force_word = 32'h0800_0040;
      tick(0, 0, 0, 0, 1);
      force_en = 0;
      chk("j_instr", InstrD, 32'h0800_0040); chk("j_pc4", PCPlus4D, 32'h14);
      tick(0, 1, 0, 0, 1);
      chk("j_addr", imem_addr, 32'h100); chk("j_valid", 32'(ValidD), 32'd0);
      tick(0, 0, 0, 0, 1);
      chk("j_tgt_instr", InstrD, 32'h2000_0100);

      // branch while holding a buffered word
      tick(1, 0, 0, 0, 1);
      tick(0, 0, 1, 32'h40, 0);
      chk("b_addr", imem_addr, 32'h40); chk("b_valid", 32'(ValidD), 32'd0);
      tick(0, 0, 0, 0, 1);
      chk("b_instr", InstrD, 32'h2000_0040);

      // redirect ignored under stall
      tick(1, 1, 1, 32'h80, 0);
      chk("ign_instr", InstrD, 32'h2000_0040); chk("ign_addr", imem_addr, 32'h44);

      // redirect with outstanding request, target masked, PC wrap
      tick(0, 0, 1, 32'hFFFF_FFFF, 0);
      chk("k_addr_frozen", imem_addr, 32'h44);
      tick(0, 0, 0, 0, 1);
      chk("k_addr_tgt", imem_addr, 32'hFFFF_FFFC); chk("k_valid", 32'(ValidD), 32'd0);
      tick(0, 0, 0, 0, 1);
      chk("wrap_instr", InstrD, 32'hFFFF_FFFC); chk("wrap_pc4", PCPlus4D, 32'h0);
      chk("wrap_addr", imem_addr, 32'h0);

      // randomized decode and memory behaviour
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] bt;
         bt = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
         tick(($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 12) == 0, bt,
              ($urandom % 3) != 0);
      end

      // asynchronous reset while a request is waiting
      for (int i = 0; i < 8 && !m_req(); i++) tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      chk("pre_rst_req", 32'(imem_req), 32'd1);
      #2 reset = 1'b0;
      #1 chk_reset_outputs("async");
      m_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      tick(0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 1);
      chk("post_rst_instr", InstrD, 32'h2000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
